// File: rtl/ahb_burst_master.sv
// AHB-Lite burst initiator: accepts one command at a time and issues SINGLE,
// INCR, INCRx and WRAPx transfers with overlapped address and data phases.
module ahb_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  // Command handshake: a command is taken on a rising edge where cmd_valid
  // and cmd_ready are both high; cmd_ready is high only while idle.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HBURST,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_LAST  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t      state;
  logic [4:0]  beats;
  logic [4:0]  issued;

  logic              resp_ok;
  logic              is_wrap;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] next_addr;

  function automatic logic [4:0] burst_beats(input logic [2:0] b, input logic [4:0] len);
    logic [4:0] n;
    unique case (b)
      3'b000:         n = 5'd1;
      3'b001:         n = (len == 5'd0) ? 5'd1 : len;
      3'b010, 3'b011: n = 5'd4;
      3'b100, 3'b101: n = 5'd8;
      default:        n = 5'd16;
    endcase
    return n;
  endfunction

  assign resp_ok   = (HRESP == 2'b00);
  assign state_dbg = state;

  // Wrapping keeps the upper address bits and lets only the in-block bits roll over.
  always_comb begin
    is_wrap   = 1'b0;
    step      = '0;
    wrap_mask = '0;
    next_addr = '0;
    is_wrap   = !HBURST[0] && (HBURST != 3'b000);
    step      = {{(ADDR_W-1){1'b0}}, 1'b1} << HSIZE;
    wrap_mask = (ADDR_W'(beats) << HSIZE) - {{(ADDR_W-1){1'b0}}, 1'b1};
    if (is_wrap)
      next_addr = (HADDR & ~wrap_mask) | ((HADDR + step) & wrap_mask);
    else
      next_addr = HADDR + step;
  end

  // A write beat is consumed on the edge that ends its address phase.
  assign wr_pop = HWRITE && HREADY &&
                  ((state == S_ADDR) || ((state == S_BURST) && resp_ok));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      beats     <= '0;
      issued    <= '0;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HBURST    <= '0;
      HSIZE     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      cmd_ready <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            HADDR     <= cmd_addr;
            HBURST    <= cmd_burst;
            HSIZE     <= cmd_size;
            HWRITE    <= cmd_write;
            HTRANS    <= TR_NONSEQ;
            beats     <= burst_beats(cmd_burst, cmd_len);
            issued    <= 5'd1;
            cmd_ready <= 1'b0;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            if (HWRITE) HWDATA <= wr_data;
            if (issued == beats) begin
              HTRANS <= TR_IDLE;
              state  <= S_LAST;
            end else begin
              HTRANS <= TR_SEQ;
              HADDR  <= next_addr;
              issued <= issued + 5'd1;
              state  <= S_BURST;
            end
          end
        end
        S_BURST: begin
          if (!resp_ok) begin
            // First error cycle: drop the pipelined address immediately.
            HTRANS <= TR_IDLE;
            if (HREADY) begin
              done      <= 1'b1;
              err       <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end else if (HREADY) begin
            if (HWRITE) begin
              HWDATA <= wr_data;
            end else begin
              rd_valid <= 1'b1;
              rd_data  <= HRDATA;
            end
            if (issued == beats) begin
              HTRANS <= TR_IDLE;
              state  <= S_LAST;
            end else begin
              HTRANS <= TR_SEQ;
              HADDR  <= next_addr;
              issued <= issued + 5'd1;
            end
          end
        end
        S_LAST: begin
          if (!resp_ok) begin
            if (HREADY) begin
              done      <= 1'b1;
              err       <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end else if (HREADY) begin
            if (!HWRITE) begin
              rd_valid <= 1'b1;
              rd_data  <= HRDATA;
            end
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_ERR: begin
          if (HREADY) begin
            done      <= 1'b1;
            err       <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Bench for ahb_burst_master: a reactive AHB slave with wait/error injection
// and an expected-queue scoreboard fed from an address-sequence model.
module tb_ahb_burst_master;

  // ---------------- clock / reset ----------------
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_burst = '0;
  logic [2:0]  cmd_size = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = '0;
  logic [2:0]  state_dbg;

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .cmd_len(cmd_len), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr_q[$];
  logic [1:0]  exp_tr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wd_q[$];
  logic        exp_done_q[$];
  logic [31:0] src_q[$];

  int cfg_wait_beat = -1, cfg_wait_n = 0, cfg_err_beat = -1;
  logic [2:0] cur_burst = '0, cur_size = '0;
  logic       cur_write = 1'b0;
  int cur_exp_pops = 0, cur_exp_active = -1;
  int pop_count = 0, pop_base = 0, active_cnt = 0, active_base = 0, done_count = 0;
  logic pop_pending = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- driver: write data source ----------------
  always @(posedge HCLK) begin
    #1;
    if (pop_pending) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      pop_count++;
    end
    wr_data = (src_q.size() > 0) ? src_q[0] : 32'h0;
  end

  // ---------------- slave model + monitor ----------------
  logic        dp_active = 1'b0, dp_write = 1'b0, prev_ready = 1'b1, prev_write = 1'b0;
  logic [31:0] dp_addr = '0, prev_addr = '0;
  logic [1:0]  prev_trans = '0;
  int          dp_beat = 0, wait_left = 0, err_stage = 0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      dp_active = 1'b0; err_stage = 0; wait_left = 0;
      HREADY = 1'b1; HRESP = 2'b00;
      prev_ready = 1'b1; prev_trans = 2'b00; pop_pending = 1'b0;
    end else begin
      if (prev_ready) begin
        if (prev_trans[1]) begin
          dp_beat   = (prev_trans == 2'b10) ? 0 : dp_beat + 1;
          dp_active = 1'b1; dp_addr = prev_addr; dp_write = prev_write; err_stage = 0;
          wait_left = (dp_beat == cfg_wait_beat) ? cfg_wait_n : 0;
        end else begin
          dp_active = 1'b0;
        end
      end
      if (!dp_active) begin
        HREADY = 1'b1; HRESP = 2'b00;
      end else if (dp_beat == cfg_err_beat) begin
        if (err_stage == 0) begin
          HREADY = 1'b0; HRESP = 2'b01; err_stage = 1;
        end else begin
          HREADY = 1'b1; HRESP = 2'b01;
          chk("err_cancel_htrans", HTRANS, 2'b00);
        end
      end else if (wait_left > 0) begin
        HREADY = 1'b0; HRESP = 2'b00; wait_left--;
      end else begin
        HREADY = 1'b1; HRESP = 2'b00;
        if (dp_write) begin
          if (exp_wd_q.size() == 0) chk("hwdata_unexpected", 1, 0);
          else chk("hwdata", HWDATA, exp_wd_q.pop_front());
        end else begin
          HRDATA = rdata_of(dp_addr);
        end
      end
      #1;
      if (HTRANS[1] && HREADY) begin
        if (exp_addr_q.size() == 0) chk("addr_unexpected", 1, 0);
        else begin
          chk("haddr", HADDR, exp_addr_q.pop_front());
          chk("htrans", HTRANS, exp_tr_q.pop_front());
          chk("hctrl", {HBURST, HSIZE, HWRITE}, {cur_burst, cur_size, cur_write});
        end
      end
      if (HTRANS[1]) begin
        active_cnt++;
        chk("busy_cmd_ready", cmd_ready, 0);
      end
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rd_data, exp_rd_q.pop_front());
      end
      if (done) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_err", err, exp_done_q.pop_front());
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_drain", exp_addr_q.size() + exp_rd_q.size() + exp_wd_q.size(), 0);
        chk("done_pops", pop_count - pop_base, cur_exp_pops);
        if (cur_exp_active >= 0) chk("done_active_cycles", active_cnt - active_base, cur_exp_active);
        done_count++;
      end
      pop_pending = wr_pop;
      prev_ready = HREADY; prev_trans = HTRANS; prev_addr = HADDR; prev_write = HWRITE;
    end
  end

  // ---------------- command driver with reference model ----------------
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] burst,
                       input logic [2:0] size, input logic [4:0] len, input int wbeat,
                       input int wn, input int ebeat, input logic fixed,
                       input logic [31:0] dbase, input logic wait_done);
    int n, e, nacc, nok, d0, k;
    logic [31:0] bytes, total, base, a, d;
    n = (burst == 3'd0) ? 1 : (burst == 3'd1) ? ((len == 5'd0) ? 1 : int'(len))
                                              : (4 << ((int'(burst) - 2) / 2));
    bytes = 32'd1 << size;
    total = 32'(n) * bytes;
    e     = (ebeat >= 0 && ebeat < n) ? ebeat : -1;
    nacc  = (e < 0) ? n : e + 1;
    nok   = (e < 0) ? n : e;
    base  = addr - (addr % total);
    src_q.delete();
    for (int i = 0; i < nacc; i++) begin
      if (burst inside {3'd2, 3'd4, 3'd6}) a = base + ((addr - base + 32'(i) * bytes) % total);
      else a = addr + 32'(i) * bytes;
      exp_addr_q.push_back(a);
      exp_tr_q.push_back((i == 0) ? 2'b10 : 2'b11);
      if (!wr && i < nok) exp_rd_q.push_back(rdata_of(a));
    end
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        d = fixed ? dbase + 32'(i) : $urandom;
        src_q.push_back(d);
        if (i < nok) exp_wd_q.push_back(d);
      end
    end
    exp_done_q.push_back(e >= 0);
    cfg_wait_beat = wbeat; cfg_wait_n = wn; cfg_err_beat = e;
    cur_burst = burst; cur_size = size; cur_write = wr;
    cur_exp_pops = wr ? nacc : 0;
    cur_exp_active = (e >= 0) ? -1 : n + ((wbeat >= 0 && wbeat < n - 1) ? wn : 0);
    pop_base = pop_count; active_base = active_cnt;
    @(posedge HCLK);
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_burst = burst;
    cmd_size = size; cmd_len = len;
    for (k = 0; k < 50 && !cmd_ready; k++) @(negedge HCLK);
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    if (wait_done) begin
      d0 = done_count;
      for (k = 0; k < 400 && done_count == d0; k++) @(negedge HCLK);
      if (done_count == d0) chk("done_timeout", 0, 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    logic [2:0] rb, rs;
    logic [31:0] ra;
    repeat (3) @(negedge HCLK);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_ctrl", {HBURST, HSIZE, HWRITE}, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_strobes", {wr_pop, rd_valid, done, err}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_state", state_dbg, 0);
    HRESET = 1'b0;

    issue(32'h38, 1'b0, 3'd2, 3'd2, 5'd0, -1, 0, -1, 1'b0, 32'h0, 1'b1);
    issue(32'h100, 1'b1, 3'd3, 3'd2, 5'd0, -1, 0, -1, 1'b1, 32'hA0, 1'b1);
    issue(32'h200, 1'b1, 3'd5, 3'd2, 5'd0, 2, 2, -1, 1'b0, 32'h0, 1'b1);
    issue(32'h1E, 1'b0, 3'd4, 3'd1, 5'd0, -1, 0, -1, 1'b0, 32'h0, 1'b1);
    issue(32'h3, 1'b1, 3'd0, 3'd0, 5'd0, -1, 0, -1, 1'b1, 32'h5C, 1'b1);
    issue(32'h400, 1'b0, 3'd7, 3'd2, 5'd0, -1, 0, 4, 1'b0, 32'h0, 1'b1);
    issue(32'h80, 1'b0, 3'd1, 3'd2, 5'd0, -1, 0, -1, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset in the middle of a WRAP16 read.
    issue(32'h600, 1'b0, 3'd6, 3'd2, 5'd0, -1, 0, -1, 1'b0, 32'h0, 1'b0);
    repeat (6) @(posedge HCLK);
    #3 HRESET = 1'b1;
    #1;
    chk("midrst_htrans", HTRANS, 0);
    chk("midrst_haddr", HADDR, 0);
    chk("midrst_ctrl", {HBURST, HSIZE, HWRITE}, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_strobes", {wr_pop, rd_valid, done, err}, 0);
    exp_addr_q.delete(); exp_tr_q.delete(); exp_rd_q.delete();
    exp_wd_q.delete(); exp_done_q.delete(); src_q.delete();
    d0 = done_count;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    chk("midrst_no_done", done_count, d0);
    issue(32'h20, 1'b1, 3'd3, 3'd2, 5'd0, -1, 0, -1, 1'b0, 32'h0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      rb = 3'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 2));
      ra = ($urandom & 32'h0000_FFFF) >> rs << rs;
      issue(ra, 1'($urandom_range(0, 1)), rb, rs, 5'($urandom_range(0, 16)),
            $urandom_range(0, 15), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1,
            1'b0, 32'h0, 1'b1);
    end

    repeat (3) @(negedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- AHB-Lite initiator that drives the bus signals consumed by the simple AHB slave (amab_ahb_simple), replacing testbench-driven pin wiggling with synthesizable master RTL.
- Accepts one burst command at a time from a local command port and issues SINGLE, INCR, INCRx and WRAPx transfers.
- Pipelines the address and data phases, honours HREADY wait states, and aborts a burst on an ERROR response.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width; the largest legal HSIZE is log2(DATA_W/8).

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_addr  in  ADDR_W  start address; must be aligned to cmd_size.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_burst  in  3  HBURST encoding.
- cmd_size  in  3  HSIZE encoding.
- cmd_len  in  5  beat count for INCR (1..16); ignored for all other bursts.
- wr_data  in  DATA_W  next write beat; must be valid whenever wr_pop is high.
- wr_pop  out  1  write beat consumed this cycle.
- rd_data  out  DATA_W  read beat.
- rd_valid  out  1  one-cycle strobe per completed read beat.
- done  out  1  one-cycle strobe when the burst finishes or aborts.
- err  out  1  valid with done; 1 = burst aborted by ERROR.
- HADDR  out  ADDR_W  bus address.
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HBURST  out  3  SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- HSIZE  out  3  transfer size.
- HWRITE  out  1  transfer direction.
- HWDATA  out  DATA_W  write data.
- HRDATA  in  DATA_W  read data.
- HREADY  in  1  transfer done / extend.
- HRESP  in  2  OKAY=00, ERROR=01; other codes are treated as ERROR.

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, HBURST=0, HSIZE=0, HWRITE=0, HWDATA=0, cmd_ready=1, wr_pop=0, rd_valid=0, done=0, err=0, rd_data=0. State = IDLE.
- Reset mid-burst returns to IDLE immediately with no done pulse.
- Beat count: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=cmd_len. cmd_len=0 is treated as 1.
- Address step: bytes = 1<<HSIZE.
  - INCR bursts: next = addr + bytes.
  - WRAP bursts: mask = beats*bytes-1; next = (addr & ~mask) | ((addr+bytes) & mask).
- 1KB boundary crossing is the command issuer's responsibility and is not checked.
- State IDLE: HTRANS=IDLE. On command accept, latch the command and move to ADDR.
- Address phase, first beat: HTRANS=NONSEQ with HADDR/HBURST/HSIZE/HWRITE.
- Later address phases: HTRANS=SEQ with the next address.
- Phase advance: only on a cycle with HREADY=1. While HREADY=0, all address-phase outputs and HWDATA hold.
- Write data: HWDATA for beat n is driven in the cycle after beat n's address phase completes, i.e. in its data phase.
  - wr_pop pulses in the cycle HWDATA is loaded, once per beat.
- Read data: rd_data is captured from HRDATA and rd_valid pulses in the cycle where a read data phase sees HREADY=1 and HRESP=OKAY.
- States: IDLE -> ADDR (first NONSEQ) -> BURST (address n+1 overlapped with data n) -> LAST (final data phase, HTRANS=IDLE) -> IDLE.
  - A 1-beat burst goes ADDR -> LAST.
- done pulses one cycle after the final data phase completes with OKAY; err=0. cmd_ready rises in the same cycle.
- Error handling:
  - An ERROR seen in a data phase with HREADY=0 is the first cycle of the two-cycle error response.
  - The master drives HTRANS=IDLE in the next cycle, cancelling any pipelined address.
  - After HREADY=1, done=1 and err=1 pulse and the state returns to IDLE.
  - No further beats are issued and no rd_valid is generated for the failed beat.
- BUSY is never generated.
- Commands offered while not IDLE are not accepted, since cmd_ready=0.

Test Plan:
- WRAP4 word read at 0x38 -> HADDR 0x38, 0x3C, 0x30, 0x34; HTRANS NONSEQ, SEQ, SEQ, SEQ, then IDLE; 4 rd_valid pulses; done with err=0.
- INCR4 word write at 0x100 with wr_data 0xA0..0xA3 -> HADDR 0x100, 0x104, 0x108, 0x10C; HWDATA trails each address by one cycle; 4 wr_pop pulses.
- INCR8 write, slave holds HREADY=0 for 2 cycles on beat 3 -> HADDR and HWDATA frozen for 2 cycles; total burst length = 8+2 cycles; data intact.
- WRAP8 halfword read at 0x1E -> 0x1E, 0x10, 0x12, ..., 0x1C; then a SINGLE byte write at 0x3 -> one NONSEQ, HBURST=000, HSIZE=000.
- INCR16 read, ERROR on beat 5 -> HTRANS=IDLE the cycle after the first error cycle; done=1 and err=1; exactly 4 rd_valid pulses.
- HRESET asserted mid WRAP16 -> outputs take their reset values asynchronously; no done pulse; a new command is accepted after deassertion.
